// File: rtl/booth_result_bcd_converter_if.sv
// booth_result_bcd_converter_if: product handshake and BCD result bundle between multiplier, converter and display.
interface booth_result_bcd_converter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS = 5
);
  logic [DATA_WIDTH-1:0] result_in;
  logic result_valid;
  logic busy;
  logic [4*DIGITS-1:0] bcd_out;
  logic sign_out;
  logic done;
  logic bcd_valid;
  modport master (
    output result_in, result_valid,
    input busy, bcd_out, sign_out, done, bcd_valid
  );
  modport slave (
    input result_in, result_valid,
    output busy, bcd_out, sign_out, done, bcd_valid
  );
endinterface

// File: rtl/booth_result_bcd_converter.sv
// booth_result_bcd_converter: iterative double-dabble of the multiplier product into sign + packed BCD.
// Define SIGNED_RESULT_EN to treat result_in as two's complement; otherwise it is unsigned and sign_out stays 0.
module booth_result_bcd_converter #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS = 5
) (
  input logic sys_clock,
  input logic reset,
  booth_result_bcd_converter_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CONVERT_DONE} state_t;
  state_t state, state_nx;
  logic [4*DIGITS-1:0] scratch, adj;
  logic [DATA_WIDTH-1:0] mag, mag_in;
  logic [CW-1:0] cnt;
  logic sign_r, sign_in;
`ifdef SIGNED_RESULT_EN
  assign sign_in = bus.result_in[DATA_WIDTH-1];
  assign mag_in = sign_in ? ~bus.result_in + DATA_WIDTH'(1) : bus.result_in;
`else
  assign sign_in = 1'b0;
  assign mag_in = bus.result_in;
`endif
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
  end
  assign bus.busy = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (bus.result_valid ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CW'(DATA_WIDTH - 1) ? CONVERT_DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state <= IDLE;
      scratch <= '0;
      mag <= '0;
      cnt <= '0;
      sign_r <= 1'b0;
      bus.bcd_out <= '0;
      bus.sign_out <= 1'b0;
      bus.done <= 1'b0;
      bus.bcd_valid <= 1'b0;
    end else begin
      state <= state_nx;
      bus.done <= state == CONVERT_DONE;
      if (state == IDLE && bus.result_valid) begin
        sign_r <= sign_in;
        mag <= mag_in;
        scratch <= '0;
        cnt <= '0;
      end
      // the adjusted top bit is always zero, so dropping it on the shift loses nothing
      if (state == SHIFT) begin
        {scratch, mag} <= {adj, mag} << 1;
        cnt <= cnt + CW'(1);
      end
      if (state == CONVERT_DONE) begin
        bus.bcd_out <= scratch;
        bus.sign_out <= sign_r;
        bus.bcd_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_booth_result_bcd_converter.sv
// tb_booth_result_bcd_converter: directed table of products plus handshake and reset-abort sequences.
module tb_booth_result_bcd_converter;
`ifdef SIGNED_RESULT_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  logic sys_clock = 1'b0;
  logic reset;
  int passed = 0;
  int total = 0;
  booth_result_bcd_converter_if bus ();
  booth_result_bcd_converter dut (.sys_clock(sys_clock), .reset(reset), .bus(bus));
  always #5 sys_clock = ~sys_clock;
  typedef struct {
    logic [15:0] v;
    logic [19:0] sb;
    logic ss;
    logic [19:0] ub;
  } vec_t;
  vec_t vecs [9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic run(input int idx, input logic [15:0] v, input logic [19:0] eb, input logic es);
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    int viol = 0;
    logic [19:0] prev_b;
    logic prev_s;
    prev_b = bus.bcd_out;
    prev_s = bus.sign_out;
    @(negedge sys_clock);
    bus.result_in = v;
    bus.result_valid = 1'b1;
    @(posedge sys_clock);
    #1 bus.result_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        @(posedge sys_clock);
        #1;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        done_at = k;
      end
      if (k < 17 && (bus.bcd_out !== prev_b || bus.sign_out !== prev_s)) viol++;
    end
    chk($sformatf("v%0d_busy_cycles", idx), busy_n, 17);
    chk($sformatf("v%0d_done_count", idx), done_n, 1);
    chk($sformatf("v%0d_done_edge", idx), done_at, 17);
    chk($sformatf("v%0d_stable", idx), viol, 0);
    chk($sformatf("v%0d_bcd", idx), {12'd0, bus.bcd_out}, {12'd0, eb});
    chk($sformatf("v%0d_sign", idx), {31'd0, bus.sign_out}, {31'd0, es});
    chk($sformatf("v%0d_bcd_valid", idx), {31'd0, bus.bcd_valid}, 32'd1);
  endtask
  initial begin
    int done_n;
    int first_at;
    int second_at;
    logic [19:0] first_b;
    logic [19:0] second_b;
    reset = 1'b1;
    bus.result_in = '0;
    bus.result_valid = 1'b0;
    repeat (2) @(posedge sys_clock);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_bcd_valid", {31'd0, bus.bcd_valid}, 0);
    chk("rst_sign", {31'd0, bus.sign_out}, 0);
    chk("rst_bcd", {12'd0, bus.bcd_out}, 0);
    @(negedge sys_clock) reset = 1'b0;
    vecs[0] = '{16'h0031, 20'h00049, 1'b0, 20'h00049};
    vecs[1] = '{16'hFFE4, 20'h00028, 1'b1, 20'h65508};
    vecs[2] = '{16'h0010, 20'h00016, 1'b0, 20'h00016};
    vecs[3] = '{16'h8000, 20'h32768, 1'b1, 20'h32768};
    vecs[4] = '{16'h7FFF, 20'h32767, 1'b0, 20'h32767};
    vecs[5] = '{16'h0000, 20'h00000, 1'b0, 20'h00000};
    vecs[6] = '{16'hFFFF, 20'h00001, 1'b1, 20'h65535};
    vecs[7] = '{16'h03E8, 20'h01000, 1'b0, 20'h01000};
    vecs[8] = '{16'h270F, 20'h09999, 1'b0, 20'h09999};
    for (int i = 0; i < 9; i++)
      run(i, vecs[i].v, SGN ? vecs[i].sb : vecs[i].ub, SGN ? vecs[i].ss : 1'b0);
    done_n = 0;
    first_at = -1;
    second_at = -1;
    first_b = '0;
    second_b = '0;
    @(negedge sys_clock);
    bus.result_in = 16'h0031;
    bus.result_valid = 1'b1;
    @(posedge sys_clock);
    #1 bus.result_valid = 1'b0;
    for (int k = 0; k < 46; k++) begin
      if (k > 0) begin
        @(posedge sys_clock);
        #1;
      end
      if (bus.done) begin
        done_n++;
        if (first_at < 0) begin
          first_at = k;
          first_b = bus.bcd_out;
        end else begin
          second_at = k;
          second_b = bus.bcd_out;
        end
      end
      if (k == 4 || k == 17) begin
        bus.result_in = 16'h0010;
        bus.result_valid = 1'b1;
      end
      if (k == 5 || k == 18) bus.result_valid = 1'b0;
    end
    chk("hs_done_count", done_n, 2);
    chk("hs_first_edge", first_at, 17);
    chk("hs_first_bcd", {12'd0, first_b}, 32'h00049);
    chk("hs_second_edge", second_at, 35);
    chk("hs_second_bcd", {12'd0, second_b}, 32'h00016);
    @(negedge sys_clock);
    bus.result_in = 16'h0031;
    bus.result_valid = 1'b1;
    @(posedge sys_clock);
    #1 bus.result_valid = 1'b0;
    repeat (7) @(posedge sys_clock);
    #1 reset = 1'b1;
    @(posedge sys_clock);
    #1 reset = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 0);
    chk("abort_bcd", {12'd0, bus.bcd_out}, 0);
    chk("abort_sign", {31'd0, bus.sign_out}, 0);
    chk("abort_bcd_valid", {31'd0, bus.bcd_valid}, 0);
    done_n = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.done) done_n++;
      @(posedge sys_clock);
      #1;
    end
    chk("abort_no_done", done_n, 0);
    run(9, 16'h0007, 20'h00007, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/booth_result_bcd_converter.md
Name: booth_result_bcd_converter

Overview:
- Downstream stage of the Booth multiplier: consumes the 16-bit two's-complement product when the multiplier's done pulse fires.
- Converts the product to sign plus 5 packed BCD digits using an iterative double-dabble engine, one shift per clock.
- Holds the converted value steady for the LED/7-segment display logic.

Parameters:
- DATA_WIDTH, 16, width of the product input; number of shift iterations.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^DATA_WIDTH.

Ports:
- sys_clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- result_in  input  DATA_WIDTH  product from the multiplier.
- result_valid  input  1  one-cycle pulse meaning result_in is final (the multiplier's done/eq fall).
- busy  output  1  high while a conversion is in progress.
- bcd_out  output  4*DIGITS  packed BCD magnitude; digit 0 is in bits [3:0].
- sign_out  output  1  1 means the product was negative.
- done  output  1  one-cycle pulse when bcd_out/sign_out update.
- bcd_valid  output  1  sticky; high once any conversion completes since reset.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - busy=0, done=0, bcd_valid=0, sign_out=0, bcd_out=0.
  - Scratch registers and iteration counter are cleared.
- IDLE: on an edge where result_valid=1:
  - Capture sign = result_in[MSB] (see Optional Feature).
  - Capture magnitude = sign ? (~result_in + 1) : result_in, as an unsigned DATA_WIDTH value. 0x8000 yields 32768 with no overflow.
  - Clear the BCD scratch; counter=0; go to SHIFT; busy=1.
- SHIFT: each edge performs one double-dabble iteration:
  - Every scratch digit ≥5 gets +3, using corrected values.
  - Then {scratch, magnitude} shifts left by 1.
  - counter increments.
  - After the DATA_WIDTH-th iteration, go to CONVERT_DONE.
- CONVERT_DONE: on the next edge:
  - bcd_out ← scratch; sign_out ← captured sign.
  - done=1 for exactly one cycle; bcd_valid=1; busy=0; return to IDLE.
- Latency:
  - Capture edge = edge 0. Shifts occur on edges 1..DATA_WIDTH. Outputs update on edge DATA_WIDTH+1 (17 by default).
  - done is high in the cycle after edge 17.
  - The earliest next capture is the edge after that (edge 18).
- Output stability: bcd_out and sign_out change only on the completion edge. Intermediate scratch values are never visible.
- result_valid while busy (SHIFT or CONVERT_DONE) is ignored and dropped; the in-flight conversion is unaffected.
- result_valid coincident with the done cycle (state IDLE) is accepted normally.
- Zero input: bcd_out=0, sign_out=0. A negative zero cannot occur.
- Reset mid-conversion: abort immediately to the reset values, with no done pulse. bcd_valid is cleared.
- result_valid high for multiple consecutive IDLE cycles: only the first edge captures; the later edges fall in SHIFT and are ignored.

Optional Feature:
- Macro SIGNED_RESULT_EN.
- Defined:
  - result_in is two's complement.
  - sign_out and magnitude are formed as above.
  - Range −32768..32767.
- Undefined:
  - result_in is unsigned, magnitude = result_in, range 0..65535.
  - sign_out is tied to 0.
  - Timing and handshake are identical.

Test Plan:
- SIGNED_RESULT_EN defined, result_in=0x0031 (7×7) with a one-cycle result_valid:
  - busy high for 17 cycles.
  - done pulses once on edge 17.
  - bcd_out=0x00049, sign_out=0, bcd_valid=1.
- SIGNED_RESULT_EN defined, result_in=0xFFE4 (7×−4) → bcd_out=0x00028, sign_out=1. Then result_in=0x0010 (−4×−4) → bcd_out=0x00016, sign_out=0.
- Boundaries, signed:
  - 0x8000 → bcd_out=0x32768, sign_out=1.
  - 0x7FFF → 0x32767, sign_out=0.
  - 0x0000 → 0x00000, sign_out=0.
- SIGNED_RESULT_EN undefined:
  - 0xFFE4 → bcd_out=0x65508, sign_out=0.
  - 0xFFFF → 0x65535.
- Handshake:
  - Pulse result_valid with 0x0031, then pulse again on edge 5 with 0x0010. The second pulse is ignored: a single done, bcd_out=0x00049.
  - A pulse in the done cycle with 0x0010 is accepted: second done, bcd_out=0x00016.
- Reset mid-conversion:
  - Assert reset on edge 8 of a conversion of 0x0031.
  - Outputs go to 0, busy=0, no done.
  - A subsequent 0x0007 converts to 0x00007 normally.
